spectral_frame_packetizer: RTL and testbench
============================================

# spectral_frame_packetizer

Parametrised frame packetizer between the line-sensor driver pixel stream and the AXI4-Stream DMA path. Each sensor frame becomes one framed packet: header, time stamp, then raw pixel pairs, intensity moments (Σy², Σy²·index), or both, then footer. The payload mode is selected per frame. Unlike the previous acquisition block, this block honours `data_tready` through an output FIFO, reports overflow and skipped frames, and asserts `tlast` on the footer of every Nth frame.

## Interface
Parameters:
- PIX_WIDTH, 12, pixel bit width; legal range 1..16.
- NUM_PIXELS, 1024, pixels per frame; must be even and at least 2.
- FIFO_DEPTH, 16, output FIFO depth in 32-bit words; must be a power of 2 and at least 8.
- Localparam IDX_WIDTH = clog2(NUM_PIXELS).

Ports:
- master_clock  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  payload mode: 0 = raw, 1 = moments, 2 = raw then moments, 3 = treated as 0. Latched at frame start.
- frames_per_burst  in  16  frames per tlast burst; 0 is treated as 1. Latched at frame start.
- pix_data  in  PIX_WIDTH  pixel value.
- pix_index  in  IDX_WIDTH  pixel index within the frame.
- pix_valid  in  1  pixel qualifier.
- data_tready  in  1  AXIS ready from the downstream sink.
- data_tdata  out  32  AXIS data.
- data_tvalid  out  1  AXIS valid.
- data_tlast  out  1  AXIS last.
- overflow  out  1  sticky flag; set when any word is dropped because the FIFO was full. Cleared only by reset.
- frame_drop_count  out  16  count of skipped frame starts; saturates at 0xFFFF.
- dbg_state  out  4  current FSM state encoding.

## Operation
- time_counter: 32 bits, free-running, +1 every cycle, wraps, cleared by reset.
- Frame start: pix_valid=1 && pix_index==0.
  - In IDLE: latch mode, latch frames_per_burst, latch time_counter into ts; go to HEADER.
  - In any other state: the frame is skipped and frame_drop_count increments.
- Pixels arrive at most one per cycle with indices ascending 0..NUM_PIXELS-1. Gaps of pix_valid=0 between pixels are allowed.
- Header and time stamp
  - HEADER: push 0xAAAAAAAA; go to TIME_STAMP.
  - TIME_STAMP: push ts.
  - In both states, if the FIFO is full the word is dropped and overflow is set; the state still advances.
- Pixel path: pixels pass through a 3-stage delay so that raw pushes never collide with the header and time-stamp pushes.
- Raw payload (modes 0 and 2): each even/odd pixel pair is pushed as {zero-padded pix[odd] in bits 31:16, zero-padded pix[even] in bits 15:0}. That is NUM_PIXELS/2 words.
  - FIFO full at push time: the word is dropped and overflow is set. There is no stall, because the sensor cannot be paused.
- Moments (modes 1 and 2), for every pixel:
  - y = pix·pix, 2·PIX_WIDTH bits.
  - c_acc += y; d_acc += y·pix_index.
  - Both accumulators are 48 bits, wrap on overflow, and are cleared at frame start.
- PAYLOAD exits when the pixel with index NUM_PIXELS-1 has left the pipeline.
  - Moments modes go to DRAIN. DRAIN waits until the accumulators are final (2 cycles), then goes to MOMENTS.
  - Mode 0 goes to FOOTER.
- MOMENTS pushes 4 words: c_acc[31:0], {16'd0, c_acc[47:32]}, d_acc[31:0], {16'd0, d_acc[47:32]}. Each word stalls while the FIFO is full; none is dropped.
- FOOTER pushes 0x55555555, stalling while full.
  - burst_cnt+1 == frames_per_burst: the word's tlast bit is set and burst_cnt resets to 0.
  - Otherwise burst_cnt increments.
  - Then go to IDLE.
- FIFO: single push per cycle and show-ahead. It stores tdata and tlast (33 bits). The AXIS outputs are driven directly from the FIFO head.
- Reset: every state is cleared, including an in-flight frame and the FIFO contents.
  - Outputs after reset: data_tvalid=0, data_tlast=0, data_tdata=0, overflow=0, frame_drop_count=0, dbg_state=IDLE.
  - burst_cnt=0 and time_counter=0.

## Timing
- A frame start sampled at cycle T:
  - header pushed at T+1, time stamp at T+2;
  - the first raw word (pixels 0 and 1, with pixel 1 at T+1) is pushed at T+4.
- Push-to-output latency: a word pushed at cycle t into an empty FIFO appears with data_tvalid=1 at t+1.
- AXIS handshake:
  - A transfer occurs when tvalid && tready.
  - While tready=0, tdata and tlast hold stable.
  - tvalid never drops without a transfer.
- Push and pop in the same cycle are both honoured. A full FIFO that is popped in a cycle accepts the push in that cycle.
- Last pixel at cycle L:
  - mode 0: footer pushed at L+4;
  - moments modes: first moment word pushed at L+6 (if the FIFO is not full), footer after the 4th moment word.
- A new frame start can be accepted from the first IDLE cycle.

## Test plan
- mode=0, NUM_PIXELS=8, pixels 0x001..0x008, tready=1 → output stream AAAAAAAA, ts, 00020001, 00040003, 00060005, 00080007, 55555555 with tlast=1 (frames_per_burst=1).
- mode=1, all pixels=2, NUM_PIXELS=8 → moment words 0x20, 0x0, 0x70, 0x0 (c=8·4; d=4·28), then footer.
- mode=2, frames_per_burst=3, three frames → tlast only on the 3rd footer; the 4th frame starts a new burst.
- tready=0 for a whole raw frame with FIFO_DEPTH=8 → the first 8 words are kept, overflow=1, and the footer stalls until tready rises; the kept words then drain in order.
- Frame start arriving during MOMENTS → frame_drop_count=1; the current packet completes intact.
- reset asserted mid-payload with tready=0 → next cycle tvalid=0 and overflow=0; the following frame produces a complete, correct packet.

Source files
------------

// File: rtl/spectral_frame_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : spectral_frame_packetizer_if
// Brief    : Pixel stream, frame config and AXIS output bundle of the packetizer.
// Revision : 1.0
// ============================================================================
interface spectral_frame_packetizer_if #(
  parameter int PIX_WIDTH = 12,
  parameter int IDX_WIDTH = 10
);
  logic [1:0]           mode;
  logic [15:0]          frames_per_burst;
  logic [PIX_WIDTH-1:0] pix_data;
  logic [IDX_WIDTH-1:0] pix_index;
  logic                 pix_valid;
  logic                 data_tready;
  logic [31:0]          data_tdata;
  logic                 data_tvalid;
  logic                 data_tlast;
  logic                 overflow;
  logic [15:0]          frame_drop_count;
  logic [3:0]           dbg_state;

  // Environment side: drives the sensor stream and the downstream ready.
  modport master (
    output mode, frames_per_burst, pix_data, pix_index, pix_valid, data_tready,
    input  data_tdata, data_tvalid, data_tlast, overflow, frame_drop_count, dbg_state
  );

  modport slave (
    input  mode, frames_per_burst, pix_data, pix_index, pix_valid, data_tready,
    output data_tdata, data_tvalid, data_tlast, overflow, frame_drop_count, dbg_state
  );
endinterface
`default_nettype wire

// File: rtl/spectral_frame_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : spectral_frame_packetizer
// Brief    : Packs sensor frames (raw pairs and/or intensity moments) into
//            framed AXIS packets through a show-ahead output FIFO.
// Revision : 1.0
// ============================================================================
module spectral_frame_packetizer #(
  parameter int PIX_WIDTH  = 12,
  parameter int NUM_PIXELS = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input wire master_clock,
  input wire reset,
  spectral_frame_packetizer_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(NUM_PIXELS);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int YW        = 2 * PIX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_PIXELS - 1);
  localparam logic [31:0]          HEADER_WORD = 32'hAAAA_AAAA;
  localparam logic [31:0]          FOOTER_WORD = 32'h5555_5555;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HEADER     = 4'd1,
    ST_TIME_STAMP = 4'd2,
    ST_PAYLOAD    = 4'd3,
    ST_DRAIN      = 4'd4,
    ST_MOMENTS    = 4'd5,
    ST_FOOTER     = 4'd6
  } state_t;

  state_t state_q, state_d;

  logic [31:0] time_q, ts_q;
  logic [1:0]  mode_q;
  logic [15:0] fpb_q, burst_q, burst_d, drop_q;
  logic [1:0]  mcnt_q, mcnt_d;
  logic        drain_q, drain_d;
  logic        acc_q, overflow_q, ovf_set;

  logic [2:0]                vld_q;
  logic [2:0][PIX_WIDTH-1:0] pix_q;
  logic [2:0][IDX_WIDTH-1:0] idx_q;
  logic [PIX_WIDTH-1:0]      even_q;
  logic [YW-1:0]             y_q, sq;
  logic [IDX_WIDTH-1:0]      yidx_q;
  logic                      yvld_q;
  logic [47:0]               c_acc_q, d_acc_q;

  logic frame_start, start_accept, take_pix, raw_mode, mom_mode, burst_hit;
  logic [15:0] fpb_eff;
  logic [16:0] burst_inc;

  logic [32:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        fifo_empty, fifo_full, pop, can_push, push_en, wr_en, push_last;
  logic [31:0] push_word;

  assign frame_start  = bus.pix_valid && (bus.pix_index == '0);
  assign start_accept = frame_start && (state_q == ST_IDLE);
  // Pixels of a skipped frame never enter the delay line.
  assign take_pix     = bus.pix_valid && (start_accept || (acc_q && !frame_start));
  assign raw_mode     = (mode_q != 2'd1);
  assign mom_mode     = (mode_q == 2'd1) || (mode_q == 2'd2);
  assign fpb_eff      = (fpb_q == 16'd0) ? 16'd1 : fpb_q;
  assign burst_inc    = {1'b0, burst_q} + 17'd1;
  assign burst_hit    = (burst_inc == {1'b0, fpb_eff});
  assign sq           = YW'(pix_q[2]) * YW'(pix_q[2]);

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = !fifo_empty && bus.data_tready;
  assign can_push   = !fifo_full || pop;
  assign wr_en      = push_en && can_push;

  always_comb begin
    state_d   = state_q;
    push_en   = 1'b0;
    push_word = 32'd0;
    push_last = 1'b0;
    ovf_set   = 1'b0;
    mcnt_d    = mcnt_q;
    drain_d   = drain_q;
    burst_d   = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (start_accept) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        push_en   = 1'b1;
        push_word = HEADER_WORD;
        ovf_set   = !can_push;
        state_d   = ST_TIME_STAMP;
      end
      ST_TIME_STAMP: begin
        push_en   = 1'b1;
        push_word = ts_q;
        ovf_set   = !can_push;
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // The sensor cannot be paused, so a raw word that finds the FIFO full is lost.
        if (vld_q[2] && idx_q[2][0] && raw_mode) begin
          push_en   = 1'b1;
          push_word = {16'(pix_q[2]), 16'(even_q)};
          ovf_set   = !can_push;
        end
        if (vld_q[2] && (idx_q[2] == LAST_IDX)) begin
          state_d = mom_mode ? ST_DRAIN : ST_FOOTER;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        mcnt_d  = 2'd0;
        if (drain_q) state_d = ST_MOMENTS;
      end
      ST_MOMENTS: begin
        push_en = 1'b1;
        case (mcnt_q)
          2'd0:    push_word = c_acc_q[31:0];
          2'd1:    push_word = {16'd0, c_acc_q[47:32]};
          2'd2:    push_word = d_acc_q[31:0];
          default: push_word = {16'd0, d_acc_q[47:32]};
        endcase
        if (can_push) begin
          mcnt_d = mcnt_q + 2'd1;
          if (mcnt_q == 2'd3) state_d = ST_FOOTER;
        end
      end
      ST_FOOTER: begin
        push_en   = 1'b1;
        push_word = FOOTER_WORD;
        push_last = burst_hit;
        if (can_push) begin
          burst_d = burst_hit ? 16'd0 : burst_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      time_q     <= 32'd0;
      ts_q       <= 32'd0;
      mode_q     <= 2'd0;
      fpb_q      <= 16'd0;
      burst_q    <= 16'd0;
      drop_q     <= 16'd0;
      mcnt_q     <= 2'd0;
      drain_q    <= 1'b0;
      acc_q      <= 1'b0;
      overflow_q <= 1'b0;
      vld_q      <= '0;
      pix_q      <= '0;
      idx_q      <= '0;
      even_q     <= '0;
      y_q        <= '0;
      yidx_q     <= '0;
      yvld_q     <= 1'b0;
      c_acc_q    <= 48'd0;
      d_acc_q    <= 48'd0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_q + 32'd1;
      burst_q <= burst_d;
      mcnt_q  <= mcnt_d;
      drain_q <= drain_d;
      if (start_accept) begin
        mode_q <= bus.mode;
        fpb_q  <= bus.frames_per_burst;
        ts_q   <= time_q;
      end
      if (start_accept)
        acc_q <= 1'b1;
      else if (take_pix && (bus.pix_index == LAST_IDX))
        acc_q <= 1'b0;
      if (frame_start && (state_q != ST_IDLE) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
      if (ovf_set) overflow_q <= 1'b1;

      vld_q <= {vld_q[1:0], take_pix};
      pix_q <= {pix_q[1:0], bus.pix_data};
      idx_q <= {idx_q[1:0], bus.pix_index};
      if (vld_q[2] && !idx_q[2][0]) even_q <= pix_q[2];

      // Moments run one stage behind the delay line: square, then accumulate.
      yvld_q <= vld_q[2];
      y_q    <= sq;
      yidx_q <= idx_q[2];
      if (start_accept) begin
        c_acc_q <= 48'd0;
        d_acc_q <= 48'd0;
      end else if (yvld_q) begin
        c_acc_q <= c_acc_q + 48'(y_q);
        d_acc_q <= d_acc_q + 48'(y_q) * 48'(yidx_q);
      end

      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge master_clock) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {push_last, push_word};
  end

  assign bus.data_tvalid      = !fifo_empty;
  assign bus.data_tdata       = fifo_empty ? 32'd0 : mem_q[rd_q[AW-1:0]][31:0];
  assign bus.data_tlast       = fifo_empty ? 1'b0 : mem_q[rd_q[AW-1:0]][32];
  assign bus.overflow         = overflow_q;
  assign bus.frame_drop_count = drop_q;
  assign bus.dbg_state        = state_q;
endmodule
`default_nettype wire

// File: tb/tb_spectral_frame_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spectral_frame_packetizer
// Brief    : Directed scenarios for the frame packetizer, 8-pixel frames, 8-word FIFO.
// Revision : 1.0
// ============================================================================
module tb_spectral_frame_packetizer;
  localparam int PW = 12;
  localparam int NP = 8;
  localparam int FD = 8;
  localparam int IW = $clog2(NP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tcount;
  logic [32:0] q_w [$];
  logic [31:0] q_t [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  spectral_frame_packetizer_if #(.PIX_WIDTH(PW), .IDX_WIDTH(IW)) bus ();

  spectral_frame_packetizer #(.PIX_WIDTH(PW), .NUM_PIXELS(NP), .FIFO_DEPTH(FD)) dut (
    .master_clock (clk),
    .reset        (rst),
    .bus          (bus)
  );

  // Reference cycle count: equals the DUT free-running time counter.
  always @(posedge clk) begin
    if (rst) tcount <= 32'd0;
    else     tcount <= tcount + 32'd1;
  end

  // Transfers are recorded on the falling edge, ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (!rst && bus.data_tvalid && bus.data_tready) begin
      q_w.push_back({bus.data_tlast, bus.data_tdata});
      q_t.push_back(tcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_w.delete();
    q_t.delete();
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 300 && q_w.size() < n; k++) tick();
  endtask

  task automatic send_frame(input bit ramp, input logic [11:0] val, output logic [31:0] ts);
    ts = tcount;
    for (int i = 0; i < NP; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_index = IW'(i);
      bus.pix_data  = ramp ? 12'(i + 1) : val;
      tick();
    end
    bus.pix_valid = 1'b0;
    bus.pix_index = '0;
    bus.pix_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests += 6;
    if (bus.data_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", bus.data_tvalid); end
    if (bus.data_tlast !== 1'b0)  begin n_fail++; $display("FAIL reset_tlast got %b want 0", bus.data_tlast); end
    if (bus.data_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", bus.data_tdata); end
    if (bus.overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    if (bus.frame_drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", bus.frame_drop_count); end
    if (bus.dbg_state !== 4'd0)   begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.dbg_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    logic [31:0] ts;
    logic [32:0] exp [7];
    clear_q();
    bus.mode = 2'd0; bus.frames_per_burst = 16'd1; bus.data_tready = 1'b1;
    send_frame(1'b1, 12'h0, ts);
    wait_words(7);
    exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts}, 33'h0_00020001, 33'h0_00040003,
            33'h0_00060005, 33'h0_00080007, 33'h1_55555555};
    n_tests++;
    if (q_w.size() != 7) begin
      n_fail++; $display("FAIL raw_count got %0d want 7", q_w.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL raw_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
      n_tests++;
      if ((q_t[0] - ts) !== 32'd2 || (q_t[2] - ts) !== 32'd5 || (q_t[6] - ts) !== 32'd12) begin
        n_fail++;
        $display("FAIL raw_timing got hdr+%0d raw0+%0d ftr+%0d want +2 +5 +12", q_t[0] - ts, q_t[2] - ts, q_t[6] - ts);
      end
    end
  endtask

  task automatic test_moments();
    logic [31:0] ts;
    logic [32:0] exp [7];
    clear_q();
    bus.mode = 2'd1; bus.frames_per_burst = 16'd1; bus.data_tready = 1'b1;
    send_frame(1'b0, 12'd2, ts);
    wait_words(7);
    exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts}, 33'h0_00000020, 33'h0_00000000,
            33'h0_00000070, 33'h0_00000000, 33'h1_55555555};
    n_tests++;
    if (q_w.size() != 7) begin
      n_fail++; $display("FAIL mom_count got %0d want 7", q_w.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL mom_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
      n_tests++;
      if ((q_t[2] - ts) !== 32'd14 || (q_t[6] - ts) !== 32'd18) begin
        n_fail++; $display("FAIL mom_timing got m0+%0d ftr+%0d want +14 +18", q_t[2] - ts, q_t[6] - ts);
      end
    end
  endtask

  task automatic test_drop();
    logic [31:0] ts, ts2;
    logic [32:0] exp [7];
    clear_q();
    bus.mode = 2'd1; bus.frames_per_burst = 16'd1; bus.data_tready = 1'b1;
    send_frame(1'b0, 12'd2, ts);
    for (int k = 0; k < 50 && bus.dbg_state != 4'd5; k++) tick();
    send_frame(1'b1, 12'h0, ts2);
    wait_words(7);
    repeat (20) tick();
    exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts}, 33'h0_00000020, 33'h0_00000000,
            33'h0_00000070, 33'h0_00000000, 33'h1_55555555};
    n_tests += 2;
    if (bus.frame_drop_count !== 16'd1) begin n_fail++; $display("FAIL drop_count got %0d want 1", bus.frame_drop_count); end
    if (q_w.size() != 7) begin
      n_fail++; $display("FAIL drop_words got %0d want 7", q_w.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL drop_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ts, ts2;
    logic [32:0] exp [9];
    clear_q();
    bus.mode = 2'd0; bus.frames_per_burst = 16'd1; bus.data_tready = 1'b0;
    send_frame(1'b1, 12'h0, ts);
    for (int k = 0; k < 50 && bus.dbg_state != 4'd0; k++) tick();
    send_frame(1'b1, 12'h0, ts2);
    repeat (10) tick();
    n_tests += 5;
    if (bus.dbg_state !== 4'd6) begin n_fail++; $display("FAIL ovf_stall_state got %0d want 6", bus.dbg_state); end
    if (bus.overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    if (bus.data_tvalid !== 1'b1) begin n_fail++; $display("FAIL ovf_tvalid got %b want 1", bus.data_tvalid); end
    if ({bus.data_tlast, bus.data_tdata} !== 33'h0_AAAAAAAA) begin
      n_fail++; $display("FAIL ovf_head got %h want 0aaaaaaaa", {bus.data_tlast, bus.data_tdata});
    end
    if (q_w.size() != 0) begin n_fail++; $display("FAIL ovf_no_xfer got %0d want 0", q_w.size()); end
    bus.data_tready = 1'b1;
    wait_words(9);
    repeat (5) tick();
    exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts}, 33'h0_00020001, 33'h0_00040003, 33'h0_00060005,
            33'h0_00080007, 33'h1_55555555, 33'h0_AAAAAAAA, 33'h1_55555555};
    n_tests += 2;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    if (q_w.size() != 9) begin
      n_fail++; $display("FAIL ovf_count got %0d want 9", q_w.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] ts [4];
    logic [32:0] exp [11];
    logic        last_exp [4];
    clear_q();
    bus.mode = 2'd2; bus.frames_per_burst = 16'd3; bus.data_tready = 1'b1;
    last_exp = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b1, 12'h0, ts[f]);
      wait_words(11 * (f + 1));
    end
    n_tests++;
    if (q_w.size() != 44) begin
      n_fail++; $display("FAIL burst_count got %0d want 44", q_w.size());
    end else begin
      exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts[0]}, 33'h0_00020001, 33'h0_00040003, 33'h0_00060005,
              33'h0_00080007, 33'h0_000000CC, 33'h0_00000000, 33'h0_00000444, 33'h0_00000000,
              33'h0_55555555};
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL burst_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
      for (int f = 0; f < 4; f++) begin
        n_tests++;
        if (q_w[11 * f + 10] !== {last_exp[f], 32'h55555555}) begin
          n_fail++; $display("FAIL burst_footer%0d got %h want tlast=%b", f, q_w[11 * f + 10], last_exp[f]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ts;
    logic [32:0] exp [7];
    bus.mode = 2'd0; bus.frames_per_burst = 16'd1; bus.data_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pix_valid = 1'b1; bus.pix_index = IW'(i); bus.pix_data = 12'(i + 1);
      tick();
    end
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests += 4;
    if (bus.data_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid got %b want 0", bus.data_tvalid); end
    if (bus.overflow !== 1'b0)    begin n_fail++; $display("FAIL rmid_overflow got %b want 0", bus.overflow); end
    if (bus.dbg_state !== 4'd0)   begin n_fail++; $display("FAIL rmid_state got %0d want 0", bus.dbg_state); end
    if (bus.frame_drop_count !== 16'd0) begin n_fail++; $display("FAIL rmid_drop got %0d want 0", bus.frame_drop_count); end
    tick();
    clear_q();
    bus.data_tready = 1'b1;
    send_frame(1'b1, 12'h0, ts);
    wait_words(7);
    exp = '{{1'b0, 32'hAAAAAAAA}, {1'b0, ts}, 33'h0_00020001, 33'h0_00040003,
            33'h0_00060005, 33'h0_00080007, 33'h1_55555555};
    n_tests++;
    if (q_w.size() != 7) begin
      n_fail++; $display("FAIL rmid_count got %0d want 7", q_w.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (q_w[i] !== exp[i]) begin n_fail++; $display("FAIL rmid_word%0d got %h want %h", i, q_w[i], exp[i]); end
      end
    end
  endtask

  initial begin
    bus.mode             = 2'd0;
    bus.frames_per_burst = 16'd1;
    bus.pix_data         = '0;
    bus.pix_index        = '0;
    bus.pix_valid        = 1'b0;
    bus.data_tready      = 1'b0;
    test_reset();
    test_raw();
    test_moments();
    test_drop();
    test_overflow();
    test_burst();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
`default_nettype wire
